// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE stream infrastructure.
// checker_rule_t encodes which stream rule a protocol checker saw broken.
package hwpe_stream_package;

   typedef enum logic [1:0] {
      RULE_NONE,
      RULE_VALUE,
      RULE_DEASSERT,
      RULE_STRB
   } checker_rule_t;

endpackage

// File: rtl/hwpe_stream_protocol_checker_chan.sv
// Single-stream monitor: handshake history, the three rule detectors, sticky flags
// and saturating beat/stall counters. viol_rule_o is this cycle's highest-priority hit.
module hwpe_stream_protocol_checker_chan
   import hwpe_stream_package::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 32,
   parameter bit          STRB_CHECK = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clear_i,
   input  logic                    enable_i,
   input  logic                    valid_i,
   input  logic                    ready_i,
   input  logic [DATA_WIDTH-1:0]   data_i,
   input  logic [DATA_WIDTH/8-1:0] strb_i,
   output logic [CNT_WIDTH-1:0]    beats_o,
   output logic [CNT_WIDTH-1:0]    stalls_o,
   output logic                    err_value_o,
   output logic                    err_deassert_o,
   output logic                    err_strb_o,
   output checker_rule_t           viol_rule_o
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic                  prev_valid;
   logic                  prev_hs;
   logic [DATA_WIDTH-1:0] prev_data;
   logic [STRB_WIDTH-1:0] prev_strb;

   logic pending;
   logic hs;
   logic stall;
   logic viol_value;
   logic viol_deassert;
   logic viol_strb;

   // A beat offered last cycle and not taken must still be on the bus, unchanged.
   assign pending       = enable_i & prev_valid & ~prev_hs;
   assign viol_value    = pending & valid_i & ((data_i != prev_data) | (strb_i != prev_strb));
   assign viol_deassert = pending & ~valid_i;
   assign viol_strb     = STRB_CHECK & enable_i & valid_i & (strb_i == '0);
   assign hs            = enable_i & valid_i & ready_i;
   assign stall         = enable_i & valid_i & ~ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prev_valid <= 1'b0;
         prev_hs    <= 1'b0;
         prev_data  <= '0;
         prev_strb  <= '0;
      end else if (clear_i) begin
         prev_valid <= 1'b0;
         prev_hs    <= 1'b0;
         prev_data  <= '0;
         prev_strb  <= '0;
      end else if (enable_i) begin
         prev_valid <= valid_i;
         prev_hs    <= valid_i & ready_i;
         prev_data  <= data_i;
         prev_strb  <= strb_i;
      end else begin
         // Dropping history here means the first cycle after re-enable is never checked.
         prev_valid <= 1'b0;
         prev_hs    <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_value_o    <= 1'b0;
         err_deassert_o <= 1'b0;
         err_strb_o     <= 1'b0;
         beats_o        <= '0;
         stalls_o       <= '0;
      end else if (clear_i) begin
         err_value_o    <= 1'b0;
         err_deassert_o <= 1'b0;
         err_strb_o     <= 1'b0;
         beats_o        <= '0;
         stalls_o       <= '0;
      end else begin
         err_value_o    <= err_value_o | viol_value;
         err_deassert_o <= err_deassert_o | viol_deassert;
         err_strb_o     <= err_strb_o | viol_strb;
         if (hs && (beats_o != '1)) begin
            beats_o <= beats_o + CNT_WIDTH'(1);
         end
         if (stall && (stalls_o != '1)) begin
            stalls_o <= stalls_o + CNT_WIDTH'(1);
         end
      end
   end

   always_comb begin
      viol_rule_o = RULE_NONE;
      if (viol_strb) begin
         viol_rule_o = RULE_STRB;
      end
      if (viol_deassert) begin
         viol_rule_o = RULE_DEASSERT;
      end
      if (viol_value) begin
         viol_rule_o = RULE_VALUE;
      end
   end

endmodule

// File: rtl/hwpe_stream_protocol_checker.sv
// Passive protocol checker for NB_CHAN HWPE streams: per-channel monitors plus a
// shared cycle timer and first-error capture for debug readout.
module hwpe_stream_protocol_checker
   import hwpe_stream_package::*;
#(
   parameter int unsigned NB_CHAN    = 1,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 32,
   parameter bit          STRB_CHECK = 1'b1,
   localparam int unsigned CHAN_W    = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1
) (
   input  logic                                    clk_i,
   input  logic                                    rst_ni,
   input  logic                                    clear_i,
   input  logic                                    enable_i,
   input  logic [NB_CHAN-1:0]                      valid_i,
   input  logic [NB_CHAN-1:0]                      ready_i,
   input  logic [NB_CHAN-1:0][DATA_WIDTH-1:0]      data_i,
   input  logic [NB_CHAN-1:0][DATA_WIDTH/8-1:0]    strb_i,
   output logic [NB_CHAN-1:0][CNT_WIDTH-1:0]       beats_o,
   output logic [NB_CHAN-1:0][CNT_WIDTH-1:0]       stalls_o,
   output logic [NB_CHAN-1:0]                      err_value_o,
   output logic [NB_CHAN-1:0]                      err_deassert_o,
   output logic [NB_CHAN-1:0]                      err_strb_o,
   output logic                                    err_o,
   output logic [CHAN_W-1:0]                       first_err_chan_o,
   output logic [1:0]                              first_err_rule_o,
   output logic [CNT_WIDTH-1:0]                    first_err_time_o
);

   checker_rule_t            viol_rule [NB_CHAN];
   logic [CNT_WIDTH-1:0]     timer_q;
   logic                     hit;
   logic [CHAN_W-1:0]        hit_chan;
   checker_rule_t            hit_rule;
   checker_rule_t            first_rule_q;

   for (genvar c = 0; c < NB_CHAN; c++) begin : g_chan
      hwpe_stream_protocol_checker_chan #(
         .DATA_WIDTH (DATA_WIDTH),
         .CNT_WIDTH  (CNT_WIDTH),
         .STRB_CHECK (STRB_CHECK)
      ) i_chan (
         .clk_i          (clk_i),
         .rst_ni         (rst_ni),
         .clear_i        (clear_i),
         .enable_i       (enable_i),
         .valid_i        (valid_i[c]),
         .ready_i        (ready_i[c]),
         .data_i         (data_i[c]),
         .strb_i         (strb_i[c]),
         .beats_o        (beats_o[c]),
         .stalls_o       (stalls_o[c]),
         .err_value_o    (err_value_o[c]),
         .err_deassert_o (err_deassert_o[c]),
         .err_strb_o     (err_strb_o[c]),
         .viol_rule_o    (viol_rule[c])
      );
   end

   assign err_o            = |{err_value_o, err_deassert_o, err_strb_o};
   assign first_err_rule_o = first_rule_q;

   // Scan from the top so the lowest violating channel is the one left standing.
   always_comb begin
      hit      = 1'b0;
      hit_chan = '0;
      hit_rule = RULE_NONE;
      for (int i = NB_CHAN - 1; i >= 0; i--) begin
         if (viol_rule[i] != RULE_NONE) begin
            hit      = 1'b1;
            hit_chan = CHAN_W'(i);
            hit_rule = viol_rule[i];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         timer_q <= '0;
      end else if (clear_i) begin
         timer_q <= '0;
      end else if (enable_i && (timer_q != '1)) begin
         timer_q <= timer_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         first_err_chan_o <= '0;
         first_rule_q     <= RULE_NONE;
         first_err_time_o <= '0;
      end else if (clear_i) begin
         first_err_chan_o <= '0;
         first_rule_q     <= RULE_NONE;
         first_err_time_o <= '0;
      end else if (hit && !err_o) begin
         first_err_chan_o <= hit_chan;
         first_rule_q     <= hit_rule;
         first_err_time_o <= timer_q;
      end
   end

endmodule

// File: tb/tb_hwpe_stream_protocol_checker.sv
// Two checkers on the same two streams: A (16-bit counters, strobe rule on) and
// B (4-bit counters, strobe rule off), checked against a transaction-level model.
module tb_hwpe_stream_protocol_checker;

   logic clk = 1'b0;
   logic rst_n;
   logic clear, en;
   logic [1:0] valid, ready;
   logic [1:0][15:0] data;
   logic [1:0][1:0]  strb;

   logic [1:0][15:0] a_beats, a_stalls;
   logic [1:0]       a_ev, a_ed, a_es;
   logic             a_err;
   logic [0:0]       a_fchan;
   logic [1:0]       a_frule;
   logic [15:0]      a_ftime;

   logic [1:0][3:0]  b_beats, b_stalls;
   logic [1:0]       b_ev, b_ed, b_es;
   logic             b_err;
   logic [0:0]       b_fchan;
   logic [1:0]       b_frule;
   logic [3:0]       b_ftime;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   hwpe_stream_protocol_checker #(
      .NB_CHAN(2), .DATA_WIDTH(16), .CNT_WIDTH(16), .STRB_CHECK(1'b1)
   ) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(en),
      .valid_i(valid), .ready_i(ready), .data_i(data), .strb_i(strb),
      .beats_o(a_beats), .stalls_o(a_stalls),
      .err_value_o(a_ev), .err_deassert_o(a_ed), .err_strb_o(a_es), .err_o(a_err),
      .first_err_chan_o(a_fchan), .first_err_rule_o(a_frule), .first_err_time_o(a_ftime)
   );

   hwpe_stream_protocol_checker #(
      .NB_CHAN(2), .DATA_WIDTH(16), .CNT_WIDTH(4), .STRB_CHECK(1'b0)
   ) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(en),
      .valid_i(valid), .ready_i(ready), .data_i(data), .strb_i(strb),
      .beats_o(b_beats), .stalls_o(b_stalls),
      .err_value_o(b_ev), .err_deassert_o(b_ed), .err_strb_o(b_es), .err_o(b_err),
      .first_err_chan_o(b_fchan), .first_err_rule_o(b_frule), .first_err_time_o(b_ftime)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: index m=0 is checker A, m=1 is checker B.
   int   m_beats [2][2];
   int   m_stalls[2][2];
   bit   m_ev[2][2], m_ed[2][2], m_es[2][2];
   int   m_fchan[2], m_frule[2], m_ftime[2], m_timer[2];
   bit   m_pend[2][2];
   logic [15:0] m_pd[2][2];
   logic [1:0]  m_ps[2][2];

   function automatic int sat_inc(int x, int maxv);
      return (x >= maxv) ? maxv : x + 1;
   endfunction

   function automatic bit any_err(int m);
      return m_ev[m][0] | m_ev[m][1] | m_ed[m][0] | m_ed[m][1] | m_es[m][0] | m_es[m][1];
   endfunction

   task automatic model_zero();
      for (int m = 0; m < 2; m++) begin
         m_fchan[m] = 0; m_frule[m] = 0; m_ftime[m] = 0; m_timer[m] = 0;
         for (int c = 0; c < 2; c++) begin
            m_beats[m][c] = 0; m_stalls[m][c] = 0;
            m_ev[m][c] = 0; m_ed[m][c] = 0; m_es[m][c] = 0;
            m_pend[m][c] = 0; m_pd[m][c] = '0; m_ps[m][c] = '0;
         end
      end
   endtask

   task automatic model_step();
      if (clear) begin
         model_zero();
         return;
      end
      for (int m = 0; m < 2; m++) begin
         int  maxv;
         bit  vv[2], vd[2], vs[2];
         bit  found;
         maxv = (m == 0) ? 65535 : 15;
         if (!en) begin
            m_pend[m][0] = 0; m_pend[m][1] = 0;
            continue;
         end
         for (int c = 0; c < 2; c++) begin
            vv[c] = m_pend[m][c] && valid[c] && (data[c] != m_pd[m][c] || strb[c] != m_ps[m][c]);
            vd[c] = m_pend[m][c] && !valid[c];
            vs[c] = (m == 0) && valid[c] && (strb[c] == 2'b00);
         end
         if (!any_err(m)) begin
            found = 0;
            for (int c = 0; c < 2; c++) begin
               if (!found && (vv[c] || vd[c] || vs[c])) begin
                  found      = 1;
                  m_fchan[m] = c;
                  m_frule[m] = vv[c] ? 1 : (vd[c] ? 2 : 3);
                  m_ftime[m] = m_timer[m];
               end
            end
         end
         for (int c = 0; c < 2; c++) begin
            m_ev[m][c] |= vv[c]; m_ed[m][c] |= vd[c]; m_es[m][c] |= vs[c];
            if (valid[c] && ready[c])  m_beats[m][c]  = sat_inc(m_beats[m][c], maxv);
            if (valid[c] && !ready[c]) m_stalls[m][c] = sat_inc(m_stalls[m][c], maxv);
            m_pend[m][c] = valid[c] && !ready[c];
            m_pd[m][c]   = data[c];
            m_ps[m][c]   = strb[c];
         end
         m_timer[m] = sat_inc(m_timer[m], maxv);
      end
   endtask

   initial begin
      model_zero();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_zero();
         else        model_step();
      end
   end

   // Every cycle out of reset, every output of both checkers against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            for (int c = 0; c < 2; c++) begin
               chk($sformatf("a_beats[%0d]", c),  a_beats[c],  m_beats[0][c]);
               chk($sformatf("a_stalls[%0d]", c), a_stalls[c], m_stalls[0][c]);
               chk($sformatf("a_ev[%0d]", c), a_ev[c], m_ev[0][c]);
               chk($sformatf("a_ed[%0d]", c), a_ed[c], m_ed[0][c]);
               chk($sformatf("a_es[%0d]", c), a_es[c], m_es[0][c]);
               chk($sformatf("b_beats[%0d]", c),  b_beats[c],  m_beats[1][c]);
               chk($sformatf("b_stalls[%0d]", c), b_stalls[c], m_stalls[1][c]);
               chk($sformatf("b_ev[%0d]", c), b_ev[c], m_ev[1][c]);
               chk($sformatf("b_ed[%0d]", c), b_ed[c], m_ed[1][c]);
               chk($sformatf("b_es[%0d]", c), b_es[c], m_es[1][c]);
            end
            chk("a_err", a_err, any_err(0));
            chk("a_fchan", a_fchan, m_fchan[0]);
            chk("a_frule", a_frule, m_frule[0]);
            chk("a_ftime", a_ftime, m_ftime[0]);
            chk("b_err", b_err, any_err(1));
            chk("b_fchan", b_fchan, m_fchan[1]);
            chk("b_frule", b_frule, m_frule[1]);
            chk("b_ftime", b_ftime, m_ftime[1]);
         end
      end
   end

   // Ends the current input cycle; new inputs are applied 2 time units after the edge.
   task automatic cyc(input int n = 1);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; en = 1'b1;
      valid = '0; ready = '0; data = '0; strb = {2'b11, 2'b11};
      cyc(2);
      chk("rst_a_err", a_err, 0);
      chk("rst_a_beats", a_beats, 0);
      chk("rst_a_ftime", a_ftime, 0);
      chk("rst_b_stalls", b_stalls, 0);
      rst_n = 1'b1;

      // Legal traffic: ch0 back-to-back, ch1 three stall cycles per beat.
      for (int k = 0; k < 40; k++) begin
         valid[0] = (k < 10); ready[0] = 1'b1; data[0] = 16'h0100 + 16'(k);
         valid[1] = 1'b1;     ready[1] = ((k % 4) == 3); data[1] = 16'h0200 + 16'(k / 4);
         cyc();
      end
      valid = '0; ready = '0;
      cyc();
      chk("legal_a_beats0", a_beats[0], 10);
      chk("legal_a_beats1", a_beats[1], 10);
      chk("legal_a_stalls1", a_stalls[1], 30);
      chk("legal_b_stalls1_sat", b_stalls[1], 15);
      chk("legal_a_err", a_err, 0);

      // Value violation on ch1 in the cycle where the timer reads 7.
      do_clear();
      cyc(6);
      valid[1] = 1'b1; ready[1] = 1'b0; data[1] = 16'h00A5;
      cyc();
      data[1] = 16'h005A;
      cyc();
      ready[1] = 1'b1;
      cyc();
      valid[1] = 1'b0; ready[1] = 1'b0;
      cyc();
      chk("val_a_ev1", a_ev[1], 1);
      chk("val_a_fchan", a_fchan, 1);
      chk("val_a_frule", a_frule, 1);
      chk("val_a_ftime", a_ftime, 7);
      chk("val_b_ftime", b_ftime, 7);

      // Same cycle: ch0 withdraws valid, ch1 changes data.
      do_clear();
      valid = 2'b11; ready = 2'b00; data[0] = 16'h0011; data[1] = 16'h0022;
      cyc();
      valid[0] = 1'b0; data[1] = 16'h0033;
      cyc();
      ready[1] = 1'b1;
      cyc();
      valid = '0; ready = '0;
      cyc();
      chk("dual_a_fchan", a_fchan, 0);
      chk("dual_a_frule", a_frule, 2);
      chk("dual_a_ftime", a_ftime, 1);
      chk("dual_a_ed0", a_ed[0], 1);
      chk("dual_a_ev1", a_ev[1], 1);

      // All-zero strobe: flagged only where the strobe rule is built in.
      do_clear();
      valid[0] = 1'b1; ready[0] = 1'b1; strb[0] = 2'b00;
      cyc();
      valid[0] = 1'b0; ready[0] = 1'b0; strb[0] = 2'b11;
      cyc();
      chk("strb_a_es0", a_es[0], 1);
      chk("strb_a_frule", a_frule, 3);
      chk("strb_b_err", b_err, 0);
      chk("strb_b_es0", b_es[0], 0);

      // Saturation, then clear on top of a deassert violation.
      do_clear();
      for (int k = 0; k < 20; k++) begin
         valid[0] = 1'b1; ready[0] = 1'b1; data[0] = 16'(k);
         if (k == 19) begin
            valid[1] = 1'b1; ready[1] = 1'b0;
         end
         cyc();
      end
      chk("sat_b_beats0", b_beats[0], 15);
      chk("sat_a_beats0", a_beats[0], 20);
      valid = '0; ready = '0; clear = 1'b1;
      cyc();
      clear = 1'b0;
      chk("clr_a_err", a_err, 0);
      chk("clr_a_beats", a_beats, 0);
      chk("clr_a_stalls", a_stalls, 0);
      chk("clr_b_beats", b_beats, 0);
      chk("clr_a_ftime", a_ftime, 0);

      // Enable gap while a beat is pending.
      cyc(3);
      valid[0] = 1'b1; ready[0] = 1'b0; data[0] = 16'h0077;
      cyc();
      en = 1'b0;
      cyc();
      valid[0] = 1'b0;
      cyc();
      en = 1'b1;
      cyc();
      valid[0] = 1'b1; ready[0] = 1'b1; strb[0] = 2'b00;
      cyc();
      valid[0] = 1'b0; ready[0] = 1'b0; strb[0] = 2'b11;
      cyc();
      chk("gap_a_ed0", a_ed[0], 0);
      chk("gap_a_frule", a_frule, 3);
      chk("gap_a_ftime", a_ftime, 5);
      chk("gap_a_stalls0", a_stalls[0], 1);
      chk("gap_b_err", b_err, 0);

      cyc(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
